int_rs_cdb_snoop: RTL and testbench
===================================

Name: int_rs_cdb_snoop

Overview:
- Integer reservation station at the receiving end of the two-slot common data bus (CDB) driven by the execute result buffer.
- Holds dispatched integer ops and snoops both CDB slots each cycle to capture missing source operands by tag.
- Issues ready entries to the integer ALU and frees an entry when the execute buffer returns that entry's index with its clear strobe.

Parameters:
- DEPTH, 4, number of RS entries (entry index width = clog2(DEPTH) = 2).
- TAG_W, 4, producer/destination tag width.
- DATA_W, 16, operand/result width.
- OP_W, 4, opcode width.
- CDB slot width is fixed at 1+TAG_W+DATA_W = 21: bit 20 valid, [19:16] tag, [15:0] data. Slot 0 is bits [20:0]; slot 1 is bits [41:21].

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- CDBData  in  42  two CDB slots.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  at least one free entry (combinational from state).
- disp_op  in  OP_W  opcode.
- disp_dtag  in  TAG_W  destination tag.
- disp_a_rdy / disp_b_rdy  in  1  source value is present.
- disp_a_tag / disp_b_tag  in  TAG_W  producer tag when not ready.
- disp_a_val / disp_b_val  in  DATA_W  source value when ready.
- iss_valid  out  1  issue slot valid (registered).
- iss_ready  in  1  ALU accepts.
- iss_op  out  OP_W  issued opcode.
- iss_a / iss_b  out  DATA_W  issued operands.
- iss_dtag  out  TAG_W  issued destination tag.
- iss_entry  out  2  entry index sent with the op.
- clr_valid  in  1  free request, from the execute buffer clear bit 0.
- clr_entry  in  2  entry to free, from the execute buffer entry index.
- flush  in  1  present only when RS_FLUSH_EN is defined.

Behaviour:
- Reset: all entries not busy and not issued; iss_valid=0; iss_op/iss_a/iss_b/iss_dtag/iss_entry=0; disp_ready=1.
- Entry state: busy, issued, op, dtag, and per source {rdy, tag, val}.
- Dispatch:
  - disp_valid & disp_ready writes the lowest-index non-busy entry at the clock edge.
  - disp_valid while disp_ready=0 is ignored; nothing is written.
- Dispatch bypass: a source with rdy=0 whose tag matches a valid CDB slot in the same cycle is written as rdy=1 with that slot's data.
- Snoop:
  - Every cycle, each busy entry's non-ready source compares its tag against slot 0 and slot 1, counting a slot only when its valid bit is set.
  - On match: val<=slot data, rdy<=1.
  - If both slots match, slot 0 wins.
  - Ready sources are never overwritten.
- Eligibility: busy & !issued & a.rdy & b.rdy, evaluated on registered state. A source captured from the CDB makes the entry eligible no earlier than the next cycle.
- Select: fixed priority, lowest eligible index.
- Issue register:
  - Loads when !iss_valid | iss_ready and an eligible entry exists.
  - On load, the selected entry gets issued<=1; the entry stays busy.
  - If iss_valid & !iss_ready, all iss_* outputs hold unchanged.
  - If iss_ready=1 and nothing is eligible, iss_valid<=0.
- Latency:
  - Dispatch of an all-ready op at edge N: iss_valid=1 after edge N+1.
  - CDB wakeup at edge N: iss_valid=1 after edge N+1.
- Free:
  - clr_valid clears busy and issued of clr_entry at the edge.
  - The freed entry is visible to disp_ready the cycle after.
  - clr_valid on a non-busy entry has no effect.
- Simultaneous events:
  - Dispatch never targets an entry being freed in the same cycle.
  - Snoop on an entry being freed is discarded.
  - Clear and issue of the same entry in one cycle: clear wins.
- Full: with all DEPTH entries busy, disp_ready=0.
- Reset mid-operation: everything returns to reset values immediately (asynchronous); any in-flight issue is lost.

Optional Feature:
- Macro: RS_FLUSH_EN.
- Defined:
  - flush=1 at an edge clears busy/issued of all entries and clears iss_valid.
  - Dispatch, snoop and clear in that cycle are ignored.
  - disp_ready=1 the next cycle.
- Undefined: the flush port and its logic are absent.

Test Plan:
- Reset, then dispatch op=3, dtag=5, a=0x0010, b=0x0020, both ready -> entry 0 busy; iss_valid=1 next cycle with iss_a=0x0010, iss_b=0x0020, iss_dtag=5, iss_entry=0.
- Dispatch with a waiting on tag 7 (b ready=0x0001); next cycle drive CDB slot 1 = {1,7,0xBEEF} -> iss_a=0xBEEF one cycle after the capture edge; no issue before that.
- Dispatch with tag 9 while CDB slot 0 = {1,9,0x1234} in the same cycle -> bypass capture; issue next cycle with iss_a=0x1234.
- Fill 4 entries (none issued) -> disp_ready=0 and a 5th dispatch is dropped; clr_valid, clr_entry=2 -> disp_ready=1 the next cycle, and the next dispatch lands in entry 2.
- Two eligible entries, iss_ready=0 for 3 cycles -> outputs hold entry 0; raise iss_ready -> entry 1 issues next cycle.
- Assert rst during a pending issue -> iss_valid=0 immediately and disp_ready=1; with RS_FLUSH_EN defined, flush on 3 busy entries -> all free next cycle.

Source files
------------

// File: rtl/int_rs_cdb_snoop.sv
// Integer reservation station that snoops the two-slot CDB to wake up waiting operands.
// Optional macro RS_FLUSH_EN adds a flush port that empties all entries and the issue slot.
module int_rs_cdb_snoop #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 16,
    parameter int OP_W   = 4,
    localparam int IDX_W  = $clog2(DEPTH),
    localparam int SLOT_W = 1 + TAG_W + DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2*SLOT_W-1:0] CDBData,
    input  logic                disp_valid,
    output logic                disp_ready,
    input  logic [OP_W-1:0]     disp_op,
    input  logic [TAG_W-1:0]    disp_dtag,
    input  logic                disp_a_rdy,
    input  logic [TAG_W-1:0]    disp_a_tag,
    input  logic [DATA_W-1:0]   disp_a_val,
    input  logic                disp_b_rdy,
    input  logic [TAG_W-1:0]    disp_b_tag,
    input  logic [DATA_W-1:0]   disp_b_val,
    output logic                iss_valid,
    input  logic                iss_ready,
    output logic [OP_W-1:0]     iss_op,
    output logic [DATA_W-1:0]   iss_a,
    output logic [DATA_W-1:0]   iss_b,
    output logic [TAG_W-1:0]    iss_dtag,
    output logic [IDX_W-1:0]    iss_entry,
    input  logic                clr_valid,
    input  logic [IDX_W-1:0]    clr_entry
`ifdef RS_FLUSH_EN
    ,
    input  logic                flush
`endif
);

    logic                flush_act;
`ifdef RS_FLUSH_EN
    assign flush_act = flush;
`else
    assign flush_act = 1'b0;
`endif

    logic [1:0]        s_valid;
    logic [TAG_W-1:0]  s_tag  [2];
    logic [DATA_W-1:0] s_data [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            assign s_valid[gi] = CDBData[gi*SLOT_W + SLOT_W - 1];
            assign s_tag[gi]   = CDBData[gi*SLOT_W + DATA_W +: TAG_W];
            assign s_data[gi]  = CDBData[gi*SLOT_W +: DATA_W];
        end
    endgenerate

    function automatic logic cdb_hit(input logic [TAG_W-1:0] tag);
        return (s_valid[0] && s_tag[0] == tag) || (s_valid[1] && s_tag[1] == tag);
    endfunction

    // Slot 0 takes priority when both slots carry the same tag.
    function automatic logic [DATA_W-1:0] cdb_data(input logic [TAG_W-1:0] tag);
        return (s_valid[0] && s_tag[0] == tag) ? s_data[0] : s_data[1];
    endfunction

    logic              busy_reg   [DEPTH];
    logic              issued_reg [DEPTH];
    logic [OP_W-1:0]   op_reg     [DEPTH];
    logic [TAG_W-1:0]  dtag_reg   [DEPTH];
    logic              a_rdy_reg  [DEPTH];
    logic [TAG_W-1:0]  a_tag_reg  [DEPTH];
    logic [DATA_W-1:0] a_val_reg  [DEPTH];
    logic              b_rdy_reg  [DEPTH];
    logic [TAG_W-1:0]  b_tag_reg  [DEPTH];
    logic [DATA_W-1:0] b_val_reg  [DEPTH];

    logic [DEPTH-1:0]  busy_vec;
    logic [DEPTH-1:0]  elig_vec;
    logic [IDX_W-1:0]  free_idx;
    logic [IDX_W-1:0]  sel_idx;
    logic              disp_fire;
    logic              issue_load;

    logic              iss_valid_reg;
    logic [OP_W-1:0]   iss_op_reg;
    logic [DATA_W-1:0] iss_a_reg;
    logic [DATA_W-1:0] iss_b_reg;
    logic [TAG_W-1:0]  iss_dtag_reg;
    logic [IDX_W-1:0]  iss_entry_reg;

    // An entry being cleared this cycle is withheld from selection so clear wins over issue.
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_vec
            assign busy_vec[gi] = busy_reg[gi];
            assign elig_vec[gi] = busy_reg[gi] && !issued_reg[gi] && a_rdy_reg[gi] && b_rdy_reg[gi]
                                  && !(clr_valid && clr_entry == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        free_idx = '0;
        sel_idx  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy_vec[i]) free_idx = IDX_W'(i);
            if (elig_vec[i])  sel_idx  = IDX_W'(i);
        end
    end

    assign disp_ready = |(~busy_vec);
    assign disp_fire  = disp_valid && disp_ready && !flush_act;
    assign issue_load = (!iss_valid_reg || iss_ready) && (|elig_vec) && !flush_act;

    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic disp_here;
            logic clr_here;
            logic iss_here;
            assign disp_here = disp_fire && free_idx == IDX_W'(gi);
            assign clr_here  = clr_valid && clr_entry == IDX_W'(gi) && busy_reg[gi];
            assign iss_here  = issue_load && sel_idx == IDX_W'(gi);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    busy_reg[gi]   <= 1'b0;
                    issued_reg[gi] <= 1'b0;
                    op_reg[gi]     <= '0;
                    dtag_reg[gi]   <= '0;
                    a_rdy_reg[gi]  <= 1'b0;
                    a_tag_reg[gi]  <= '0;
                    a_val_reg[gi]  <= '0;
                    b_rdy_reg[gi]  <= 1'b0;
                    b_tag_reg[gi]  <= '0;
                    b_val_reg[gi]  <= '0;
                end else if (flush_act || clr_here) begin
                    busy_reg[gi]   <= 1'b0;
                    issued_reg[gi] <= 1'b0;
                end else if (disp_here) begin
                    busy_reg[gi]   <= 1'b1;
                    issued_reg[gi] <= 1'b0;
                    op_reg[gi]     <= disp_op;
                    dtag_reg[gi]   <= disp_dtag;
                    a_tag_reg[gi]  <= disp_a_tag;
                    a_rdy_reg[gi]  <= disp_a_rdy || cdb_hit(disp_a_tag);
                    a_val_reg[gi]  <= disp_a_rdy ? disp_a_val : cdb_data(disp_a_tag);
                    b_tag_reg[gi]  <= disp_b_tag;
                    b_rdy_reg[gi]  <= disp_b_rdy || cdb_hit(disp_b_tag);
                    b_val_reg[gi]  <= disp_b_rdy ? disp_b_val : cdb_data(disp_b_tag);
                end else begin
                    if (iss_here) issued_reg[gi] <= 1'b1;
                    if (busy_reg[gi] && !a_rdy_reg[gi] && cdb_hit(a_tag_reg[gi])) begin
                        a_rdy_reg[gi] <= 1'b1;
                        a_val_reg[gi] <= cdb_data(a_tag_reg[gi]);
                    end
                    if (busy_reg[gi] && !b_rdy_reg[gi] && cdb_hit(b_tag_reg[gi])) begin
                        b_rdy_reg[gi] <= 1'b1;
                        b_val_reg[gi] <= cdb_data(b_tag_reg[gi]);
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_valid_reg <= 1'b0;
            iss_op_reg    <= '0;
            iss_a_reg     <= '0;
            iss_b_reg     <= '0;
            iss_dtag_reg  <= '0;
            iss_entry_reg <= '0;
        end else if (flush_act) begin
            iss_valid_reg <= 1'b0;
        end else if (issue_load) begin
            iss_valid_reg <= 1'b1;
            iss_op_reg    <= op_reg[sel_idx];
            iss_a_reg     <= a_val_reg[sel_idx];
            iss_b_reg     <= b_val_reg[sel_idx];
            iss_dtag_reg  <= dtag_reg[sel_idx];
            iss_entry_reg <= sel_idx;
        end else if (iss_ready) begin
            iss_valid_reg <= 1'b0;
        end
    end

    assign iss_valid = iss_valid_reg;
    assign iss_op    = iss_op_reg;
    assign iss_a     = iss_a_reg;
    assign iss_b     = iss_b_reg;
    assign iss_dtag  = iss_dtag_reg;
    assign iss_entry = iss_entry_reg;

endmodule

// File: tb/tb_int_rs_cdb_snoop.sv
// Scoreboard bench for int_rs_cdb_snoop: directed dispatches push expected issues,
// a negedge monitor pops and compares every accepted issue.
module tb_int_rs_cdb_snoop;

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  dtag;
        logic [1:0]  entry;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [41:0] CDBData = '0;
    logic        disp_valid = 1'b0;
    logic        disp_ready;
    logic [3:0]  disp_op = '0;
    logic [3:0]  disp_dtag = '0;
    logic        disp_a_rdy = 1'b0;
    logic [3:0]  disp_a_tag = '0;
    logic [15:0] disp_a_val = '0;
    logic        disp_b_rdy = 1'b0;
    logic [3:0]  disp_b_tag = '0;
    logic [15:0] disp_b_val = '0;
    logic        iss_valid;
    logic        iss_ready = 1'b1;
    logic [3:0]  iss_op;
    logic [15:0] iss_a;
    logic [15:0] iss_b;
    logic [3:0]  iss_dtag;
    logic [1:0]  iss_entry;
    logic        clr_valid = 1'b0;
    logic [1:0]  clr_entry = '0;
`ifdef RS_FLUSH_EN
    logic        flush = 1'b0;
`endif

    int   tests = 0;
    int   fails = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    int_rs_cdb_snoop dut (
        .clk(clk), .rst(rst), .CDBData(CDBData),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op), .disp_dtag(disp_dtag),
        .disp_a_rdy(disp_a_rdy), .disp_a_tag(disp_a_tag), .disp_a_val(disp_a_val),
        .disp_b_rdy(disp_b_rdy), .disp_b_tag(disp_b_tag), .disp_b_val(disp_b_val),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op), .iss_a(iss_a), .iss_b(iss_b),
        .iss_dtag(iss_dtag), .iss_entry(iss_entry), .clr_valid(clr_valid), .clr_entry(clr_entry)
`ifdef RS_FLUSH_EN
        , .flush(flush)
`endif
    );

    // Monitor: every accepted issue must match the oldest expected one.
    always @(negedge clk) begin
        if (!rst && iss_valid && iss_ready) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("[TB] FAIL issue_unexpected: got op=%h a=%h b=%h dtag=%h entry=%0d, required none",
                         iss_op, iss_a, iss_b, iss_dtag, iss_entry);
            end else begin
                exp_t e;
                e = q.pop_front();
                if ({iss_op, iss_a, iss_b, iss_dtag, iss_entry} !== e) begin
                    fails++;
                    $display("[TB] FAIL issue_payload: got op=%h a=%h b=%h dtag=%h entry=%0d, required op=%h a=%h b=%h dtag=%h entry=%0d",
                             iss_op, iss_a, iss_b, iss_dtag, iss_entry, e.op, e.a, e.b, e.dtag, e.entry);
                end else begin
                    $display("[TB] issue op=%h a=%h b=%h dtag=%h entry=%0d ok",
                             iss_op, iss_a, iss_b, iss_dtag, iss_entry);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, req);
        end else begin
            $display("[TB] check %s = %h ok", name, act);
        end
    endtask

    task automatic disp(input logic [3:0] op, input logic [3:0] dtag,
                        input logic ar, input logic [3:0] at, input logic [15:0] av,
                        input logic br, input logic [3:0] bt, input logic [15:0] bv);
        disp_valid = 1'b1;
        disp_op = op;     disp_dtag = dtag;
        disp_a_rdy = ar;  disp_a_tag = at;  disp_a_val = av;
        disp_b_rdy = br;  disp_b_tag = bt;  disp_b_val = bv;
        tick();
        disp_valid = 1'b0;
    endtask

    task automatic clr(input logic [1:0] e);
        clr_valid = 1'b1;
        clr_entry = e;
        tick();
        clr_valid = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("reset_iss_valid", {31'd0, iss_valid}, 32'd0);
        chk("reset_disp_ready", {31'd0, disp_ready}, 32'd1);
        chk("reset_iss_payload", {6'd0, iss_op, iss_a, iss_dtag, iss_entry}, 32'd0);
        rst = 1'b0;
        tick();

        // All-ready dispatch issues one cycle after the write edge.
        q.push_back('{op:4'd3, a:16'h0010, b:16'h0020, dtag:4'd5, entry:2'd0});
        disp(4'd3, 4'd5, 1'b1, 4'd0, 16'h0010, 1'b1, 4'd0, 16'h0020);
        chk("t1_no_early_issue", {31'd0, iss_valid}, 32'd0);
        tick();
        chk("t1_issue_valid", {31'd0, iss_valid}, 32'd1);
        clr(2'd0);

        // Wakeup from CDB slot 1.
        q.push_back('{op:4'd1, a:16'hBEEF, b:16'h0001, dtag:4'd2, entry:2'd0});
        disp(4'd1, 4'd2, 1'b0, 4'd7, 16'h0000, 1'b1, 4'd0, 16'h0001);
        CDBData = {1'b1, 4'd7, 16'hBEEF, 21'd0};
        tick();
        CDBData = '0;
        chk("t2_no_issue_at_capture", {31'd0, iss_valid}, 32'd0);
        tick();
        chk("t2_issue_valid", {31'd0, iss_valid}, 32'd1);
        clr(2'd0);

        // Dispatch-time bypass from CDB slot 0.
        q.push_back('{op:4'd2, a:16'h1234, b:16'h0002, dtag:4'd3, entry:2'd0});
        CDBData = {21'd0, 1'b1, 4'd9, 16'h1234};
        disp(4'd2, 4'd3, 1'b0, 4'd9, 16'h0000, 1'b1, 4'd0, 16'h0002);
        CDBData = '0;
        chk("t3_no_early_issue", {31'd0, iss_valid}, 32'd0);
        tick();
        chk("t3_issue_valid", {31'd0, iss_valid}, 32'd1);
        clr(2'd0);

        // Fill, drop a dispatch while full, free entry 2 and refill it.
        for (int i = 0; i < 4; i++)
            disp(4'(i), 4'(i), 1'b0, 4'hF, 16'h0000, 1'b1, 4'd0, 16'h0000);
        chk("t4_full_not_ready", {31'd0, disp_ready}, 32'd0);
        disp(4'hF, 4'hF, 1'b1, 4'd0, 16'hDEAD, 1'b1, 4'd0, 16'hDEAD);
        chk("t4_still_full", {31'd0, disp_ready}, 32'd0);
        clr(2'd2);
        chk("t4_ready_after_clear", {31'd0, disp_ready}, 32'd1);
        q.push_back('{op:4'd7, a:16'h0077, b:16'h0088, dtag:4'hA, entry:2'd2});
        disp(4'd7, 4'hA, 1'b1, 4'd0, 16'h0077, 1'b1, 4'd0, 16'h0088);
        tick();
        chk("t4_refill_issue_entry", {30'd0, iss_entry}, 32'd2);
        tick();
        for (int i = 0; i < 4; i++) clr(2'(i));

        // Back-pressure holds entry 0, then entry 1 follows.
        iss_ready = 1'b0;
        q.push_back('{op:4'd4, a:16'h0100, b:16'h0200, dtag:4'd1, entry:2'd0});
        q.push_back('{op:4'd5, a:16'h0300, b:16'h0400, dtag:4'd2, entry:2'd1});
        disp(4'd4, 4'd1, 1'b1, 4'd0, 16'h0100, 1'b1, 4'd0, 16'h0200);
        disp(4'd5, 4'd2, 1'b1, 4'd0, 16'h0300, 1'b1, 4'd0, 16'h0400);
        chk("t5_first_valid", {31'd0, iss_valid}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_hold", {iss_valid, 9'd0, iss_entry, iss_op, iss_a}, {1'b1, 9'd0, 2'd0, 4'd4, 16'h0100});
        end
        iss_ready = 1'b1;
        tick();
        chk("t5_second", {iss_valid, 9'd0, iss_entry, iss_op, iss_a}, {1'b1, 9'd0, 2'd1, 4'd5, 16'h0300});
        tick();
        chk("t5_drained", {31'd0, iss_valid}, 32'd0);

        // Asynchronous reset while an issue is pending.
        iss_ready = 1'b0;
        disp(4'd6, 4'd6, 1'b1, 4'd0, 16'h0600, 1'b1, 4'd0, 16'h0700);
        tick();
        chk("t6_pending", {31'd0, iss_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_iss_valid", {31'd0, iss_valid}, 32'd0);
        chk("t6_async_disp_ready", {31'd0, disp_ready}, 32'd1);
        chk("t6_async_payload", {iss_a, iss_b}, 32'd0);
        tick();
        rst = 1'b0;
        iss_ready = 1'b1;
        tick();

`ifdef RS_FLUSH_EN
        for (int i = 0; i < 3; i++)
            disp(4'(i), 4'(i), 1'b0, 4'hE, 16'h0000, 1'b1, 4'd0, 16'h0000);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t7_flush_ready", {31'd0, disp_ready}, 32'd1);
        q.push_back('{op:4'd8, a:16'h0011, b:16'h0022, dtag:4'hC, entry:2'd0});
        disp(4'd8, 4'hC, 1'b1, 4'd0, 16'h0011, 1'b1, 4'd0, 16'h0022);
        tick();
        chk("t7_flush_reuse_entry0", {31'd0, iss_valid}, 32'd1);
        tick();
`endif

        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
